// File: rtl/bitvec_index_encoder_if.sv
// Handshake bundle for bitvec_index_encoder: vector input side and index-beat output side.
interface bitvec_index_encoder_if #(
    parameter int unsigned N = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [2**N-1:0]   in_vec;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_idx;
    logic              out_last;
    logic              out_none;
    logic [N:0]        out_count;

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none, out_count
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none, out_count
    );
endinterface

// File: rtl/bitvec_index_encoder.sv
// Serializes the set-bit indices of a 2**N-bit multi-hot vector, lowest index
// first, one index per valid/ready beat; one vector in flight at a time.
module bitvec_index_encoder #(
    parameter int unsigned N = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    bitvec_index_encoder_if.slave  bus
);
    localparam int unsigned W = 2**N;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t         state;
    logic [W-1:0]   pending;
    logic           none_flag;
    logic [N-1:0]   low_idx;
    logic           single_bit;

    function automatic logic [N:0] popcount(input logic [W-1:0] v);
        logic [N:0] c;
        c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            c = c + (N+1)'(v[i]);
        end
        return c;
    endfunction

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = W; i > 0; i--) begin
            if (pending[i-1]) begin
                low_idx = N'(i - 1);
            end
        end
    end

    assign single_bit   = (pending != '0) && ((pending & (pending - W'(1))) == '0);
    assign bus.out_idx  = low_idx;
    assign bus.out_last = none_flag || single_bit;
    assign bus.out_none = none_flag;
    assign bus.in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= '0;
            none_flag     <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        pending       <= bus.in_vec;
                        none_flag     <= (bus.in_vec == '0);
                        bus.out_count <= popcount(bus.in_vec);
                        bus.out_valid <= 1'b1;
                        state         <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        // Clearing the lowest set bit advances to the next index.
                        pending <= pending & (pending - W'(1));
                        if (bus.out_last) begin
                            none_flag     <= 1'b0;
                            bus.out_valid <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitvec_index_encoder.sv
// Scoreboard bench for bitvec_index_encoder (N=3): directed cases plus random vectors.
module tb_bitvec_index_encoder;
    typedef struct packed {
        logic [2:0] idx;
        logic       last;
        logic       none;
        logic [3:0] count;
    } beat_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   ready_mode;
    beat_t exp_q[$];
    logic  ready_pat[$];
    logic  pend_pat[$];

    bitvec_index_encoder_if #(.N(3)) bus();

    bitvec_index_encoder #(.N(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the bits in ascending order and list the set positions.
    task automatic push_expected(input logic [7:0] v);
        int    cnt;
        int    seen;
        beat_t b;
        cnt  = $countones(v);
        seen = 0;
        if (v == 8'h00) begin
            b = '{idx: 3'd0, last: 1'b1, none: 1'b1, count: 4'd0};
            exp_q.push_back(b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    seen++;
                    b = '{idx: 3'(i), last: (seen == cnt), none: 1'b0, count: 4'(cnt)};
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // out_ready driver: 0 = always ready, 1 = random, 2 = scripted pattern then ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: bus.out_ready = 1'($urandom_range(0, 1));
                2: bus.out_ready = (ready_pat.size() != 0) ? ready_pat.pop_front() : 1'b1;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares every presented beat (stalled or accepted) against the queue head.
    always @(negedge clk) begin
        beat_t got;
        if (!rst && bus.out_valid) begin
            got = '{idx: bus.out_idx, last: bus.out_last, none: bus.out_none, count: bus.out_count};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected: got idx=%0d last=%0b none=%0b count=%0d expected no beat",
                         got.idx, got.last, got.none, got.count);
            end else begin
                if (got !== exp_q[0]) begin
                    failures++;
                    $display("FAIL beat: got idx=%0d last=%0b none=%0b count=%0d expected idx=%0d last=%0b none=%0b count=%0d",
                             got.idx, got.last, got.none, got.count,
                             exp_q[0].idx, exp_q[0].last, exp_q[0].none, exp_q[0].count);
                end
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        if (pend_pat.size() != 0) begin
            ready_pat = pend_pat;
            pend_pat.delete();
            ready_mode = 2;
        end
        push_expected(v);
        bus.in_vec   = v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input logic [3:0] count);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_leftover", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_out_count", 32'(bus.out_count), 32'(count));
    endtask

    initial begin
        logic [7:0] v;
        checks       = 0;
        failures     = 0;
        ready_mode   = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_vec   = '0;

        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_none", 32'(bus.out_none), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        #9;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        send(8'b1010_0100);
        drain(4'd3);

        send(8'h00);
        drain(4'd0);

        send(8'hFF);
        drain(4'd8);

        pend_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        send(8'h81);
        drain(4'd2);

        send(8'h0F);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_out_count", 32'(bus.out_count), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        send(8'h10);
        drain(4'd1);

        send(8'b0110_0010);
        bus.in_vec   = 8'hFF;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            chk("busy_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain(4'd3);

        ready_mode = 1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 7))
                0: v = 8'h00;
                1: v = 8'hFF;
                2: v = 8'h80;
                default: v = 8'($urandom);
            endcase
            send(v);
            if (k % 8 == 7) begin
                drain(4'($countones(v)));
            end
        end
        drain(4'($countones(v)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
